// File: rtl/alu_iter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// alu_iter - multi-cycle EX-stage ALU with internal {V,Z,N,C} flag register;
// define ALU_ITER_MUL_EN to add op 13 (iterative MUL).          Rev 1.0
// ----------------------------------------------------------------------------
module alu_iter #(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             illegal,
  output logic [3:0]       flags,
  input  logic             flags_load,
  input  logic [3:0]       flags_in
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2} state_t;

  localparam int MSB = WIDTH - 1;
  localparam logic [4:0] OP_NOP = 5'd0, OP_NOT = 5'd1, OP_INC = 5'd2, OP_DEC = 5'd3;
  localparam logic [4:0] OP_MOV = 5'd4, OP_ADD = 5'd5, OP_SUB = 5'd6, OP_AND = 5'd7;
  localparam logic [4:0] OP_OR = 5'd8, OP_SHL = 5'd9, OP_SHR = 5'd10;
  localparam logic [4:0] OP_SETC = 5'd11, OP_CLRC = 5'd12;
`ifdef ALU_ITER_MUL_EN
  localparam logic [4:0] OP_MUL = 5'd13;
`endif
  localparam logic [WIDTH-1:0] W_AS_DATA = WIDTH'(WIDTH);
  localparam logic [CNT_W-1:0] W_AS_CNT  = CNT_W'(WIDTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             illegal_q, illegal_d;
  logic             out_valid_q, out_valid_d;
  logic [3:0]       flags_q, flags_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             shr_q, shr_d;
`ifdef ALU_ITER_MUL_EN
  logic               mul_q, mul_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [2*WIDTH-1:0] prod_next;
  logic               prod_hi_nz;
`endif

  logic [WIDTH:0]   sum, diff, inc, dec;
  logic [WIDTH-1:0] dec_r;
  logic             dec_c, dec_v, dec_zn, dec_ill;
  logic [3:0]       dec_flags;
  logic [CNT_W-1:0] shift_n;
  logic [WIDTH-1:0] shifted;
  logic             shift_out;

  assign in_ready  = (state_q == S_IDLE) & ~flags_load;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign illegal   = illegal_q;
  assign flags     = flags_q;

  // Single-cycle datapath, evaluated on the raw inputs at acceptance.
  always_comb begin
    sum     = {1'b0, a} + {1'b0, b};
    diff    = {1'b0, a} - {1'b0, b};
    inc     = {1'b0, a} + (WIDTH+1)'(1);
    dec     = {1'b0, a} - (WIDTH+1)'(1);
    dec_r   = '0;
    dec_c   = flags_q[0];
    dec_v   = flags_q[3];
    dec_zn  = 1'b0;
    dec_ill = 1'b0;
    case (op)
      OP_NOP:  ;
      OP_NOT:  begin dec_r = ~a; dec_zn = 1'b1; end
      OP_INC:  begin {dec_c, dec_r} = inc; dec_zn = 1'b1; end
      OP_DEC:  begin {dec_c, dec_r} = dec; dec_zn = 1'b1; end
      OP_MOV:  dec_r = b;
      OP_ADD:  begin
        {dec_c, dec_r} = sum;
        dec_v  = (a[MSB] == b[MSB]) & (sum[MSB] != a[MSB]);
        dec_zn = 1'b1;
      end
      OP_SUB:  begin
        {dec_c, dec_r} = diff;
        dec_v  = (a[MSB] != b[MSB]) & (diff[MSB] != a[MSB]);
        dec_zn = 1'b1;
      end
      OP_AND:  begin dec_r = a & b; dec_zn = 1'b1; end
      OP_OR:   begin dec_r = a | b; dec_zn = 1'b1; end
      OP_SHL, OP_SHR: ;
      OP_SETC: dec_c = 1'b1;
      OP_CLRC: dec_c = 1'b0;
`ifdef ALU_ITER_MUL_EN
      OP_MUL:  ;
`endif
      default: dec_ill = 1'b1;
    endcase
    dec_flags = {dec_v, dec_zn ? (dec_r == '0) : flags_q[2],
                 dec_zn ? dec_r[MSB] : flags_q[1], dec_c};
    shift_n   = (b >= W_AS_DATA) ? W_AS_CNT : b[CNT_W-1:0];
    shifted   = shr_q ? {1'b0, acc_q[MSB:1]} : {acc_q[MSB-1:0], 1'b0};
    shift_out = shr_q ? acc_q[0] : acc_q[MSB];
  end

  always_comb begin
    state_d     = state_q;
    result_d    = result_q;
    illegal_d   = illegal_q;
    out_valid_d = out_valid_q;
    flags_d     = flags_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    shr_d       = shr_q;
`ifdef ALU_ITER_MUL_EN
    mul_d      = mul_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    prod_d     = prod_q;
    prod_next  = prod_q + (mplier_q[0] ? mcand_q : '0);
    prod_hi_nz = |prod_next[2*WIDTH-1:WIDTH];
`endif
    case (state_q)
      S_IDLE: begin
        if (flags_load) begin
          flags_d = flags_in;
        end else if (in_valid) begin
          if (op == OP_SHL || op == OP_SHR) begin
            shr_d = (op == OP_SHR);
            acc_d = a;
            cnt_d = shift_n;
`ifdef ALU_ITER_MUL_EN
            mul_d = 1'b0;
`endif
            if (shift_n == '0) begin
              result_d    = a;
              illegal_d   = 1'b0;
              flags_d     = {flags_q[3], a == '0, a[MSB], 1'b0};
              out_valid_d = 1'b1;
              state_d     = S_DONE;
            end else begin
              state_d = S_BUSY;
            end
          end
`ifdef ALU_ITER_MUL_EN
          else if (op == OP_MUL) begin
            mul_d    = 1'b1;
            mcand_d  = {{WIDTH{1'b0}}, a};
            mplier_d = b;
            prod_d   = '0;
            cnt_d    = W_AS_CNT;
            state_d  = S_BUSY;
          end
`endif
          else begin
            result_d    = dec_r;
            illegal_d   = dec_ill;
            flags_d     = dec_ill ? flags_q : dec_flags;
            out_valid_d = 1'b1;
            state_d     = S_DONE;
          end
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q - CNT_W'(1);
`ifdef ALU_ITER_MUL_EN
        if (mul_q) begin
          prod_d   = prod_next;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          if (cnt_q == CNT_W'(1)) begin
            result_d    = prod_next[WIDTH-1:0];
            illegal_d   = 1'b0;
            flags_d     = {prod_hi_nz, prod_next[WIDTH-1:0] == '0, prod_next[MSB], prod_hi_nz};
            out_valid_d = 1'b1;
            state_d     = S_DONE;
          end
        end else
`endif
        begin
          acc_d = shifted;
          // The flag C reflects only the bit shifted out on the final step.
          if (cnt_q == CNT_W'(1)) begin
            result_d    = shifted;
            illegal_d   = 1'b0;
            flags_d     = {flags_q[3], shifted == '0, shifted[MSB], shift_out};
            out_valid_d = 1'b1;
            state_d     = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      result_q    <= '0;
      illegal_q   <= 1'b0;
      out_valid_q <= 1'b0;
      flags_q     <= 4'b0000;
      acc_q       <= '0;
      cnt_q       <= '0;
      shr_q       <= 1'b0;
`ifdef ALU_ITER_MUL_EN
      mul_q       <= 1'b0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      prod_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      illegal_q   <= illegal_d;
      out_valid_q <= out_valid_d;
      flags_q     <= flags_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      shr_q       <= shr_d;
`ifdef ALU_ITER_MUL_EN
      mul_q       <= mul_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      prod_q      <= prod_d;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_iter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_alu_iter - directed self-checking bench for alu_iter (WIDTH=16).  Rev 1.0
// ----------------------------------------------------------------------------
module tb_alu_iter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  op = 5'd0;
  logic [15:0] a = 16'h0;
  logic [15:0] b = 16'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] result;
  logic        illegal;
  logic [3:0]  flags;
  logic        flags_load = 1'b0;
  logic [3:0]  flags_in = 4'h0;

  int errors = 0;
  int checks = 0;
  int lat;
  logic rdy_seen;

  alu_iter #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .illegal(illegal), .flags(flags), .flags_load(flags_load), .flags_in(flags_in)
  );

  always #5 clk = ~clk;

  // Presents one op, returns edges from acceptance to out_valid (-1 on timeout)
  // and whether in_ready was ever seen high while waiting.
  task automatic do_op(input logic [4:0] o, input logic [15:0] av, input logic [15:0] bv,
                       output int l, output logic rdy);
    @(negedge clk);
    op = o; a = av; b = bv; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    l = 1;
    rdy = in_ready;
    while (!out_valid && l < 100) begin
      @(posedge clk); #1;
      l++;
      rdy = rdy | in_ready;
    end
    if (!out_valid) l = -1;
  endtask

  task automatic finish_op();
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    checks++; if (result !== 16'h0) begin errors++; $display("FAIL rst_result: got %h want 0000", result); end
    checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL rst_illegal: got %b want 0", illegal); end
    checks++; if (flags !== 4'b0000) begin errors++; $display("FAIL rst_flags: got %b want 0000", flags); end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_add();
    do_op(5'd5, 16'h7FFF, 16'h0001, lat, rdy_seen);
    checks++; if (lat !== 1) begin errors++; $display("FAIL add_latency: got %0d want 1", lat); end
    checks++; if (result !== 16'h8000) begin errors++; $display("FAIL add_result: got %h want 8000", result); end
    checks++; if (flags !== 4'b1010) begin errors++; $display("FAIL add_flags: got %b want 1010", flags); end
    finish_op();
  endtask

  task automatic test_sub();
    do_op(5'd6, 16'h0003, 16'h0005, lat, rdy_seen);
    checks++; if (result !== 16'hFFFE) begin errors++; $display("FAIL sub_result: got %h want fffe", result); end
    checks++; if (flags !== 4'b0011) begin errors++; $display("FAIL sub_flags: got %b want 0011", flags); end
    finish_op();
  endtask

  task automatic test_shl();
    do_op(5'd9, 16'h8001, 16'd4, lat, rdy_seen);
    checks++; if (lat !== 5) begin errors++; $display("FAIL shl4_latency: got %0d want 5", lat); end
    checks++; if (result !== 16'h0010) begin errors++; $display("FAIL shl4_result: got %h want 0010", result); end
    checks++; if (flags !== 4'b0000) begin errors++; $display("FAIL shl4_flags: got %b want 0000", flags); end
    checks++; if (rdy_seen !== 1'b0) begin errors++; $display("FAIL shl4_in_ready: got %b want 0", rdy_seen); end
    finish_op();
    do_op(5'd9, 16'h8001, 16'd1, lat, rdy_seen);
    checks++; if (lat !== 2) begin errors++; $display("FAIL shl1_latency: got %0d want 2", lat); end
    checks++; if (result !== 16'h0002) begin errors++; $display("FAIL shl1_result: got %h want 0002", result); end
    checks++; if (flags !== 4'b0001) begin errors++; $display("FAIL shl1_flags: got %b want 0001", flags); end
    finish_op();
  endtask

  task automatic test_shr();
    do_op(5'd10, 16'h00F0, 16'd20, lat, rdy_seen);
    checks++; if (lat !== 17) begin errors++; $display("FAIL shr_sat_latency: got %0d want 17", lat); end
    checks++; if (result !== 16'h0000) begin errors++; $display("FAIL shr_sat_result: got %h want 0000", result); end
    checks++; if (flags !== 4'b0100) begin errors++; $display("FAIL shr_sat_flags: got %b want 0100", flags); end
    finish_op();
    do_op(5'd10, 16'h1234, 16'd0, lat, rdy_seen);
    checks++; if (lat !== 1) begin errors++; $display("FAIL shr0_latency: got %0d want 1", lat); end
    checks++; if (result !== 16'h1234) begin errors++; $display("FAIL shr0_result: got %h want 1234", result); end
    checks++; if (flags !== 4'b0000) begin errors++; $display("FAIL shr0_flags: got %b want 0000", flags); end
    finish_op();
  endtask

  task automatic test_backpressure();
    do_op(5'd7, 16'hF0F0, 16'hFF00, lat, rdy_seen);
    checks++; if (flags !== 4'b0010) begin errors++; $display("FAIL and_flags: got %b want 0010", flags); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_valid !== 1'b1 || result !== 16'hF000 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold_cycle%0d: got valid=%b result=%h ready=%b want 1 f000 0", i, out_valid, result, in_ready);
      end
      @(posedge clk); #1;
    end
    finish_op();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL handshake_release: got valid=%b ready=%b want 0 1", out_valid, in_ready); end
  endtask

  task automatic test_rst_abort();
    @(negedge clk);
    op = 5'd9; a = 16'h0001; b = 16'd10; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0 || flags !== 4'b0000 || in_ready !== 1'b1) begin
      errors++; $display("FAIL rst_abort: got valid=%b flags=%b ready=%b want 0 0000 1", out_valid, flags, in_ready);
    end
    @(negedge clk); rst = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_abort_dropped: got valid=%b want 0", out_valid); end
  endtask

  task automatic test_flags_load();
    @(negedge clk);
    flags_load = 1'b1; flags_in = 4'b1011; in_valid = 1'b1; op = 5'd5; a = 16'h1; b = 16'h1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fload_in_ready: got %b want 0", in_ready); end
    @(posedge clk); #1;
    flags_load = 1'b0; in_valid = 1'b0;
    checks++; if (flags !== 4'b1011) begin errors++; $display("FAIL fload_flags: got %b want 1011", flags); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL fload_no_accept: got valid=%b ready=%b want 0 1", out_valid, in_ready); end
  endtask

  task automatic test_carry_illegal();
    do_op(5'd12, 16'hAAAA, 16'h5555, lat, rdy_seen);
    checks++; if (flags !== 4'b1010 || result !== 16'h0) begin errors++; $display("FAIL clrc: got flags=%b result=%h want 1010 0000", flags, result); end
    finish_op();
    do_op(5'd11, 16'hAAAA, 16'h5555, lat, rdy_seen);
    checks++; if (flags !== 4'b1011) begin errors++; $display("FAIL setc: got flags=%b want 1011", flags); end
    finish_op();
    do_op(5'd14, 16'hFFFF, 16'hFFFF, lat, rdy_seen);
    checks++; if (illegal !== 1'b1 || result !== 16'h0 || flags !== 4'b1011) begin
      errors++; $display("FAIL op14: got ill=%b result=%h flags=%b want 1 0000 1011", illegal, result, flags);
    end
    finish_op();
`ifdef ALU_ITER_MUL_EN
    do_op(5'd13, 16'h0100, 16'h0101, lat, rdy_seen);
    checks++; if (lat !== 17 || result !== 16'h0100 || flags !== 4'b1001 || illegal !== 1'b0) begin
      errors++; $display("FAIL mul: got lat=%0d result=%h flags=%b ill=%b want 17 0100 1001 0", lat, result, flags, illegal);
    end
    finish_op();
    do_op(5'd12, 16'h0, 16'h0, lat, rdy_seen);
    do_op(5'd2, 16'h0, 16'h0, lat, rdy_seen);
    finish_op();
    flags_load = 1'b0;
    @(negedge clk); flags_load = 1'b1; flags_in = 4'b1011;
    @(posedge clk); #1; flags_load = 1'b0;
`else
    do_op(5'd13, 16'h0100, 16'h0101, lat, rdy_seen);
    checks++; if (illegal !== 1'b1 || result !== 16'h0 || flags !== 4'b1011 || lat !== 1) begin
      errors++; $display("FAIL op13_illegal: got ill=%b result=%h flags=%b lat=%0d want 1 0000 1011 1", illegal, result, flags, lat);
    end
    finish_op();
`endif
  endtask

  task automatic test_back_to_back();
    do_op(5'd2, 16'hFFFF, 16'h0, lat, rdy_seen);
    checks++; if (result !== 16'h0000 || flags !== 4'b1101 || illegal !== 1'b0) begin
      errors++; $display("FAIL inc_wrap: got result=%h flags=%b ill=%b want 0000 1101 0", result, flags, illegal);
    end
    finish_op();
    do_op(5'd3, 16'h0000, 16'h0, lat, rdy_seen);
    checks++; if (result !== 16'hFFFF || flags !== 4'b1011) begin errors++; $display("FAIL dec_wrap: got result=%h flags=%b want ffff 1011", result, flags); end
    finish_op();
    do_op(5'd4, 16'h0000, 16'h5555, lat, rdy_seen);
    checks++; if (result !== 16'h5555 || flags !== 4'b1011) begin errors++; $display("FAIL mov: got result=%h flags=%b want 5555 1011", result, flags); end
    finish_op();
    do_op(5'd8, 16'h0000, 16'h0000, lat, rdy_seen);
    checks++; if (result !== 16'h0000 || flags !== 4'b1101) begin errors++; $display("FAIL or_zero: got result=%h flags=%b want 0000 1101", result, flags); end
    finish_op();
    do_op(5'd1, 16'h00FF, 16'h0, lat, rdy_seen);
    checks++; if (result !== 16'hFF00 || flags !== 4'b1011) begin errors++; $display("FAIL not: got result=%h flags=%b want ff00 1011", result, flags); end
    finish_op();
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_shl();
    test_shr();
    test_backpressure();
    test_rst_abort();
    test_flags_load();
    test_carry_illegal();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_iter.md
Name: alu_iter

Overview:
- Parametrised, multi-cycle successor to the processor's combinational ALU. It sits in the EX stage, with a valid/ready handshake on both sides.
- Holds its own condition-code register (Z, N, C, V), so the pipeline no longer feeds flags back in.
- Shifts run iteratively, one bit per cycle, bounded by WIDTH. Adds a flag-restore port for RTI/interrupt return.

Parameters:
- WIDTH, 16, operand/result width in bits (>=4).
- CNT_W, $clog2(WIDTH+1), shift/multiply counter width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  operation presented.
- in_ready  out  1  block can accept an operation this cycle.
- op  in  5  opcode: 0 NOP, 1 NOT, 2 INC, 3 DEC, 4 MOV, 5 ADD, 6 SUB, 7 AND, 8 OR, 9 SHL, 10 SHR, 11 SETC, 12 CLRC, 13 MUL (optional); others illegal.
- a  in  WIDTH  first operand (Rdst).
- b  in  WIDTH  second operand (Rsrc / shift amount).
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes result.
- result  out  WIDTH  registered result.
- illegal  out  1  qualifies result; opcode was illegal.
- flags  out  4  {V,Z,N,C} condition-code register.
- flags_load  in  1  load flags_in into the flag register.
- flags_in  in  4  {V,Z,N,C} restore value.

Behaviour:
- Reset: state=IDLE; result=0; out_valid=0; illegal=0; flags=4'b0000; counter=0.
- FSM states: IDLE, BUSY, DONE.
- in_ready = (state==IDLE) & ~flags_load. An operation is accepted when in_valid & in_ready; a, b and op are latched.
- flags_load in IDLE writes flags_in next edge, then stays IDLE. In BUSY/DONE it is ignored (no effect).
- IDLE to DONE, one-cycle ops (0-8, 11, 12, illegal): out_valid rises the edge after acceptance.
- IDLE to BUSY, SHL/SHR:
  - Count n = min(b, WIDTH); b >= WIDTH saturates to WIDTH.
  - If n==0, go straight to DONE with result=a and C=0.
  - Otherwise shift one bit per cycle for n cycles; C = the last bit shifted out. SHL shifts in 0 at the LSB; SHR is logical.
  - BUSY to DONE after the n-th shift, so out_valid appears n+1 edges after acceptance.
- DONE: result, illegal and out_valid are held stable until out_ready; then go to IDLE and drop out_valid. A new op can be accepted the cycle after the handshake at the earliest.
- Flags commit on the same edge as the DONE entry. The flags value seen with out_valid is the post-op value.
- Arithmetic: computed at WIDTH+1 bits; Z = (r==0); N = r[WIDTH-1].
  - ADD: C = carry out; V = (a[msb]==b[msb]) & (r[msb]!=a[msb]).
  - SUB: r = a-b; C = borrow (a<b unsigned); V = (a[msb]!=b[msb]) & (r[msb]!=a[msb]).
  - INC/DEC: r = a±1; C = carry/borrow out; Z and N updated; V unchanged.
  - NOT/AND/OR: update Z and N; C and V unchanged.
  - SHL/SHR: update Z, N, C; V unchanged.
  - MOV: r = b. NOP: r = 0. SETC/CLRC: r = 0, C = 1/0. All other flags unchanged for these.
  - Illegal opcode: r = 0, illegal = 1, flags unchanged.
- rst mid-operation (BUSY or DONE) aborts: return to IDLE, apply reset values, drop the pending result.
- No combinational path from in_valid/op to out_valid or result.

Optional Feature:
- Macro: ALU_ITER_MUL_EN.
- Defined: op 13 = MUL, unsigned shift-add, one partial product per cycle.
  - BUSY for exactly WIDTH cycles; out_valid WIDTH+1 edges after acceptance.
  - result = low WIDTH bits of the product. C = V = (high WIDTH bits != 0). Z and N taken from the low half.
- Undefined: op 13 is illegal (result 0, illegal=1, flags unchanged); no multiplier logic is synthesised.

Test Plan:
- WIDTH=16, ADD a=16'h7FFF, b=16'h0001 -> after 1 edge: result=16'h8000, flags V=1, Z=0, N=1, C=0.
- SUB a=16'h0003, b=16'h0005 -> result=16'hFFFE, C=1, N=1, V=0, Z=0.
- SHL a=16'h8001, b=4 -> out_valid exactly 5 edges after acceptance, result=16'h0010, C=0; in_ready=0 throughout. Repeat with b=1 -> result=16'h0002, C=1.
- SHR a=16'h00F0, b=20 (saturates to 16) -> result=0, C=0, Z=1 after 17 edges. SHR b=0 -> result=a, C=0, 1-edge latency.
- Backpressure: hold out_ready=0 for 5 cycles after an AND result -> result and out_valid stable, in_ready=0. Assert rst during a SHL BUSY -> next cycle out_valid=0, flags=0, in_ready=1.
- flags_load with flags_in=4'b1011 in IDLE, with in_valid=1 the same cycle -> op not accepted, flags=4'b1011. Then SETC -> C=1, V/Z/N unchanged. Then op 14 -> illegal=1, flags unchanged.
